// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the spacing in clock cycles between rising edges of tick
// Ports:
//   clock, reset   - single clock; synchronous active-high reset
//   enable         - measurement enable; low holds the meter idle and clears stable
//   tick           - monitored stream, already synchronous to clock
//   period_ready   - consumer accepts the current result
//   period         - last measured period (all-ones when overflow is set)
//   period_valid   - a result is waiting for the consumer
//   overflow       - the true period exceeded 2^PERIOD_WIDTH-1
//   overrun        - sticky; a result replaced one that was never consumed
//   stable         - last two loaded results were equal and neither overflowed
// Build option: TICK_PERIOD_METER_TIMEOUT_EN reports a dead stream as an overflow
//   result as soon as the counter saturates, then waits for a fresh edge to re-arm.
module tick_period_meter #(
    parameter int PERIOD_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    tick,
    input  logic                    period_ready,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    overflow,
    output logic                    overrun,
    output logic                    stable
);
    typedef enum logic {IDLE, MEASURE} state_t;
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;
    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
    logic                    sat_q, sat_d, tick_q;
    logic                    valid_q, valid_d, ovf_q, ovf_d;
    logic                    overrun_q, overrun_d, stable_q, stable_d;
    logic                    edge_w, load, res_ovf;
    assign edge_w = tick & ~tick_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        load    = 1'b0;
        res_ovf = sat_q;
        case (state_q)
            IDLE: begin
                if (enable && edge_w) begin
                    state_d = MEASURE;
                    cnt_d   = PERIOD_WIDTH'(1);
                    sat_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else if (edge_w) begin
                    load  = 1'b1;
                    cnt_d = PERIOD_WIDTH'(1);
                    sat_d = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + PERIOD_WIDTH'(1);
                end else begin
`ifdef TICK_PERIOD_METER_TIMEOUT_EN
                    // cnt_q is already all-ones, so the result carries the saturated period
                    load    = 1'b1;
                    res_ovf = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
`else
                    sat_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // A result taken in the same cycle as a new load is not an overrun
    assign period_d  = load ? cnt_q : period_q;
    assign ovf_d     = load ? res_ovf : ovf_q;
    assign valid_d   = load | (valid_q & ~period_ready);
    assign overrun_d = overrun_q | (load & valid_q & ~period_ready);
    assign stable_d  = !enable ? 1'b0 :
                       load ? (cnt_q == period_q) & ~res_ovf & ~ovf_q : stable_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            tick_q    <= 1'b0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
            stable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            tick_q    <= tick;
            period_q  <= period_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            overrun_q <= overrun_d;
            stable_q  <= stable_d;
        end
    end
    assign period       = period_q;
    assign period_valid = valid_q;
    assign overflow     = ovf_q;
    assign overrun      = overrun_q;
    assign stable       = stable_q;
endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: self-checking bench for tick_period_meter with PERIOD_WIDTH=8
module tb_tick_period_meter;
    typedef struct {
        int p;
        bit o;
        bit s;
    } res_t;
    typedef struct {
        int gap;
        bit v;
        int p;
        bit o;
        bit s;
    } vec_t;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic       period_ready = 1'b1;
    logic [7:0] period;
    logic       period_valid, overflow, overrun, stable;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    bit         sb_en = 1'b0;
    res_t       exp_q[$];
    vec_t       vecs[13];
    int         found;

    tick_period_meter #(.PERIOD_WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .tick        (tick),
        .period_ready(period_ready),
        .period      (period),
        .period_valid(period_valid),
        .overflow    (overflow),
        .overrun     (overrun),
        .stable      (stable)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock cycle with tick driven to t; outputs are sampled on the falling edge
    task automatic cyc(input logic t);
        res_t r;
        tick = t;
        @(posedge clock);
        @(negedge clock);
        if (sb_en && period_valid && period_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: result period=%0d overflow=%0d arrived, none expected", period, overflow);
            end else begin
                r = exp_q.pop_front();
                chk("sb_period", int'(period), r.p);
                chk("sb_overflow", int'(overflow), int'(r.o));
                chk("sb_stable", int'(stable), int'(r.s));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        reset = 1'b0;
    endtask

    task automatic expect_result(input int p, input bit o, input bit s);
        res_t r;
        r.p = p;
        r.o = o;
        r.s = s;
        exp_q.push_back(r);
    endtask

    initial begin
        // gap = cycles since the previous rising edge
        vecs = '{
            '{3,   0, 0,   0, 0},
            '{5,   1, 5,   0, 0},
            '{5,   1, 5,   0, 1},
            '{5,   1, 5,   0, 1},
            '{2,   1, 2,   0, 0},
            '{2,   1, 2,   0, 1},
            '{2,   1, 2,   0, 1},
            '{255, 1, 255, 0, 0},
            '{255, 1, 255, 0, 1},
            '{256, 1, 255, 1, 0},
            '{300, 1, 255, 1, 0},
            '{255, 1, 255, 0, 0},
            '{7,   1, 7,   0, 0}
        };
        do_reset();
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_stable", int'(stable), 0);

        enable = 1'b1;
        period_ready = 1'b1;
        sb_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            repeat (vecs[i].gap - 1) cyc(1'b0);
            if (vecs[i].v) expect_result(vecs[i].p, vecs[i].o, vecs[i].s);
            cyc(1'b1);
        end
        cyc(1'b0);
        chk("table_drain", exp_q.size(), 0);

        // Overwrite of an unconsumed result sets overrun
        sb_en = 1'b0;
        do_reset();
        period_ready = 1'b0;
        cyc(1'b1);
        repeat (6) cyc(1'b0);
        cyc(1'b1);
        chk("ovr_first_valid", int'(period_valid), 1);
        chk("ovr_first_period", int'(period), 7);
        chk("ovr_first_overrun", int'(overrun), 0);
        repeat (8) cyc(1'b0);
        cyc(1'b1);
        chk("ovr_second_period", int'(period), 9);
        chk("ovr_second_valid", int'(period_valid), 1);
        chk("ovr_second_overrun", int'(overrun), 1);
        period_ready = 1'b1;
        cyc(1'b0);
        chk("ovr_taken_valid", int'(period_valid), 0);
        chk("ovr_taken_period", int'(period), 9);
        chk("ovr_sticky", int'(overrun), 1);

        // Consumer takes the old result in the same cycle as the new load
        do_reset();
        period_ready = 1'b0;
        cyc(1'b1);
        repeat (6) cyc(1'b0);
        cyc(1'b1);
        chk("nov_first_period", int'(period), 7);
        repeat (8) cyc(1'b0);
        period_ready = 1'b1;
        cyc(1'b1);
        chk("nov_second_period", int'(period), 9);
        chk("nov_second_valid", int'(period_valid), 1);
        chk("nov_overrun", int'(overrun), 0);
        cyc(1'b0);
        chk("nov_taken_valid", int'(period_valid), 0);

        // enable dropped mid-measurement discards the partial interval
        do_reset();
        sb_en = 1'b1;
        cyc(1'b1);
        repeat (4) cyc(1'b0);
        expect_result(5, 0, 0);
        cyc(1'b1);
        repeat (4) cyc(1'b0);
        expect_result(5, 0, 1);
        cyc(1'b1);
        chk("en_stable_before", int'(stable), 1);
        cyc(1'b0);
        cyc(1'b0);
        enable = 1'b0;
        cyc(1'b0);
        chk("en_stable_cleared", int'(stable), 0);
        cyc(1'b1);
        cyc(1'b0);
        enable = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        repeat (5) cyc(1'b0);
        expect_result(6, 0, 0);
        cyc(1'b1);

        // reset three cycles after an edge; first edge afterwards only re-arms
        cyc(1'b0);
        cyc(1'b0);
        reset = 1'b1;
        cyc(1'b0);
        reset = 1'b0;
        chk("mid_rst_period", int'(period), 0);
        chk("mid_rst_valid", int'(period_valid), 0);
        chk("mid_rst_overflow", int'(overflow), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        chk("mid_rst_stable", int'(stable), 0);
        cyc(1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);
        expect_result(4, 0, 0);
        cyc(1'b1);
        cyc(1'b0);
        chk("post_rst_drain", exp_q.size(), 0);

        // Single edge followed by silence
        sb_en = 1'b0;
        do_reset();
        cyc(1'b1);
        found = -1;
        for (int i = 1; i <= 300 && found < 0; i++) begin
            cyc(1'b0);
            if (period_valid) found = i;
        end
`ifdef TICK_PERIOD_METER_TIMEOUT_EN
        chk("timeout_cycle", found, 255);
        chk("timeout_period", int'(period), 255);
        chk("timeout_overflow", int'(overflow), 1);
        cyc(1'b1);
        chk("timeout_rearm_valid", int'(period_valid), 0);
`else
        chk("silence_no_result", found, -1);
        cyc(1'b1);
        chk("late_edge_valid", int'(period_valid), 1);
        chk("late_edge_period", int'(period), 255);
        chk("late_edge_overflow", int'(overflow), 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
